rsa_stream_ctrl: RTL and testbench

- Upstream sequencer for the RSA encoder. It accepts a valid/ready stream of K-bit plaintext words and buffers them in a small FIFO.
- It feeds the encoder one word at a time: holds the word on the encoder data input, pulses the encoder start, then waits for the encoder done.
- It captures the encoder result and presents it on a valid/ready output stream.
- A watchdog aborts any encoding that never completes.

---
 rtl/rsa_pkg.sv | 23 ++
 rtl/rsa_sync_fifo.sv | 43 ++++
 rtl/rsa_stream_ctrl.sv | 140 ++++++++++++++
 tb/tb_rsa_stream_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared defaults, FSM state encoding and sizing helper for the RSA stream controller.
package rsa_pkg;

   localparam int K_DEF = 7;
   localparam int N_DEF = 79;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      HOLD  = 2'd3
   } state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         r++;
      end
      return r;
   endfunction

endpackage

// File: rtl/rsa_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; push and pop may happen in the same cycle.
module rsa_sync_fifo
   import rsa_pkg::*;
#(
   parameter int WIDTH = 7,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = clog2(DEPTH);

   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;
   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   // Same index with differing wrap bits means the writer has lapped the reader.
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/rsa_stream_ctrl.sv
// Buffers plaintext words and feeds them one at a time to the RSA encoder with a watchdog.
// Optional word range rejection at pop time: RSA_STREAM_RANGE_CHECK_EN.
module rsa_stream_ctrl
   import rsa_pkg::*;
#(
   parameter int K          = K_DEF,
   parameter int N          = N_DEF,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 1024
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic [K-1:0] s_data,
   output logic         m_valid,
   input  logic         m_ready,
   output logic [K-1:0] m_data,
   output logic         enc_start,
   output logic [K-1:0] enc_data_in,
   input  logic [K-1:0] enc_data_out,
   input  logic         enc_done,
   output logic         busy,
   output logic         err,
   output logic         timeout
);

   localparam int             WDW       = clog2(TIMEOUT) + 1;
   localparam int             WD_LAST_I = TIMEOUT - 1;
   localparam logic [WDW-1:0] WD_LAST   = WD_LAST_I[WDW-1:0];
   localparam logic [K:0]     N_W       = N[K:0];

   state_t         state_q;
   logic [WDW-1:0] wd_q;
   logic [WDW-1:0] wd_inc;
   logic           m_valid_q;
   logic [K-1:0]   m_data_q;
   logic           enc_start_q;
   logic [K-1:0]   enc_data_q;
   logic           err_q;
   logic           timeout_q;

   logic           fifo_full;
   logic           fifo_empty;
   logic [K-1:0]   fifo_head;
   logic           fifo_push;
   logic           fifo_pop;
   logic           head_ok;

   assign s_ready   = !rst && !fifo_full;
   assign fifo_push = s_valid && s_ready;
   assign fifo_pop  = (state_q == IDLE) && !fifo_empty;
   assign wd_inc    = wd_q + 1'b1;

`ifdef RSA_STREAM_RANGE_CHECK_EN
   assign head_ok = ({1'b0, fifo_head} < N_W);
`else
   logic unused_n;
   assign unused_n = ^N_W;
   assign head_ok  = 1'b1;
`endif

   rsa_sync_fifo #(
      .WIDTH (K),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push),
      .wdata_i (s_data),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         wd_q        <= '0;
         m_valid_q   <= 1'b0;
         m_data_q    <= '0;
         enc_start_q <= 1'b0;
         enc_data_q  <= '0;
         err_q       <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         enc_start_q <= 1'b0;
         err_q       <= 1'b0;
         timeout_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!fifo_empty) begin
                  if (head_ok) begin
                     enc_data_q  <= fifo_head;
                     enc_start_q <= 1'b1;
                     state_q     <= START;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            START: begin
               wd_q    <= '0;
               state_q <= WAIT;
            end
            WAIT: begin
               // wd_q is still zero in the first WAIT cycle, which masks a stale done level.
               if (wd_q != '0 && enc_done) begin
                  m_data_q  <= enc_data_out;
                  m_valid_q <= 1'b1;
                  state_q   <= HOLD;
               end else if (wd_inc == WD_LAST) begin
                  wd_q      <= wd_inc;
                  timeout_q <= 1'b1;
                  state_q   <= IDLE;
               end else begin
                  wd_q <= wd_inc;
               end
            end
            HOLD: begin
               if (m_ready) begin
                  m_valid_q <= 1'b0;
                  state_q   <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign m_valid     = m_valid_q;
   assign m_data      = m_data_q;
   assign enc_start   = enc_start_q;
   assign enc_data_in = enc_data_q;
   assign err         = err_q;
   assign timeout     = timeout_q;
   assign busy        = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_rsa_stream_ctrl.sv
// Directed bench for rsa_stream_ctrl with a (x*3) mod 79 encoder model, done 20 cycles after start.
module tb_rsa_stream_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       s_valid;
   logic       s_ready;
   logic [6:0] s_data;
   logic       m_valid;
   logic       m_ready;
   logic [6:0] m_data;
   logic       enc_start;
   logic [6:0] enc_data_in;
   logic [6:0] enc_data_out;
   logic       enc_done;
   logic       busy;
   logic       err;
   logic       timeout;

   int checks = 0;
   int errors = 0;

   rsa_stream_ctrl #(
      .K          (7),
      .N          (79),
      .FIFO_DEPTH (4),
      .TIMEOUT    (64)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_data       (s_data),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .enc_start    (enc_start),
      .enc_data_in  (enc_data_in),
      .enc_data_out (enc_data_out),
      .enc_done     (enc_done),
      .busy         (busy),
      .err          (err),
      .timeout      (timeout)
   );

   always #5 clk = ~clk;

   // Encoder model
   int         enc_cnt;
   logic [6:0] enc_arg;
   logic       enc_hang;

   function automatic logic [6:0] enc_f(input logic [6:0] x);
      int r;
      r = (int'(x) * 3) % 79;
      return r[6:0];
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         enc_cnt      <= 0;
         enc_done     <= 1'b0;
         enc_data_out <= 7'd0;
         enc_arg      <= 7'd0;
      end else begin
         enc_done <= 1'b0;
         if (enc_start && !enc_hang) begin
            enc_cnt <= 19;
            enc_arg <= enc_data_in;
         end else if (enc_cnt != 0) begin
            enc_cnt <= enc_cnt - 1;
            if (enc_cnt == 1) begin
               enc_done     <= 1'b1;
               enc_data_out <= enc_f(enc_arg);
            end
         end
      end
   end

   // Event log
   int cyc    = 0;
   int wr_n   = 0;
   int err_n  = 0;
   int wr_cyc[$];
   int start_cyc[$];
   int start_dat[$];
   int done_cyc[$];
   int out_cyc[$];
   int out_dat[$];
   int to_cyc[$];
   int stall_wr = -1;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst) begin
         if (s_valid && s_ready) begin
            wr_n <= wr_n + 1;
            wr_cyc.push_back(cyc);
         end
         if (enc_start) begin
            start_cyc.push_back(cyc);
            start_dat.push_back(int'(enc_data_in));
         end
         if (enc_done) done_cyc.push_back(cyc);
         if (m_valid && m_ready) begin
            out_cyc.push_back(cyc);
            out_dat.push_back(int'(m_data));
         end
         if (timeout) to_cyc.push_back(cyc);
         if (err) err_n <= err_n + 1;
      end
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input int w);
      int g;
      int n0;
      g  = 0;
      n0 = wr_n;
      s_data  = w[6:0];
      s_valid = 1'b1;
      while (wr_n == n0 && g < 2000) begin
         if (!s_ready && stall_wr < 0) stall_wr = wr_n;
         @(negedge clk);
         g++;
      end
      s_valid = 1'b0;
      chk("push_accept", int'(wr_n != n0), 1);
   endtask

   task automatic wait_outs(input int target, input int budget);
      int g;
      g = 0;
      while (out_dat.size() < target && g < budget) begin
         @(negedge clk);
         g++;
      end
      chk("wait_outputs", int'(out_dat.size() >= target), 1);
   endtask

   task automatic wait_mvalid(input int budget);
      int g;
      g = 0;
      while (!m_valid && g < budget) begin
         @(negedge clk);
         g++;
      end
      chk("wait_m_valid", int'(m_valid), 1);
   endtask

   initial begin
      int sb;
      int ob;
      int wb;
      int eb;
      int tb0;
      int h;
      int bad;
      int g;

      rst      = 1'b1;
      s_valid  = 1'b0;
      s_data   = 7'd0;
      m_ready  = 1'b1;
      enc_hang = 1'b0;

      // Reset values
      tick(3);
      chk("rst_s_ready", int'(s_ready), 0);
      chk("rst_m_valid", int'(m_valid), 0);
      chk("rst_enc_start", int'(enc_start), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_err_timeout", int'({err, timeout}), 0);
      chk("rst_data", int'({m_data, enc_data_in}), 0);
      rst = 1'b0;
      tick(1);
      chk("post_rst_s_ready", int'(s_ready), 1);

      // Single word
      sb = start_cyc.size();
      wb = wr_cyc.size();
      push(5);
      wait_mvalid(200);
      chk("single_m_data", int'(m_data), 15);
      chk("single_done_latency", cyc - done_cyc[done_cyc.size() - 1], 1);
      chk("single_start_latency", start_cyc[sb] - wr_cyc[wb], 2);
      chk("single_enc_data_in", start_dat[sb], 5);
      tick(1);
      chk("single_busy_after", int'(busy), 0);
      chk("single_m_valid_after", int'(m_valid), 0);

      // Burst of six with downstream always ready
      sb = start_cyc.size();
      ob = out_dat.size();
      wb = wr_n;
      stall_wr = -1;
      for (int i = 1; i <= 6; i++) push(i);
      chk("burst_stall_point", stall_wr - wb, 5);
      wait_outs(ob + 6, 400);
      tick(5);
      for (int i = 0; i < 6; i++) begin
         chk("burst_out", out_dat[ob + i], 3 * (i + 1));
         chk("burst_start_data", start_dat[sb + i], i + 1);
      end
      chk("burst_start_count", start_cyc.size() - sb, 6);

      // Backpressure
      m_ready = 1'b0;
      sb = start_cyc.size();
      ob = out_dat.size();
      push(5);
      push(1);
      push(2);
      wait_mvalid(200);
      bad = 0;
      repeat (50) begin
         @(negedge clk);
         if (!m_valid || m_data != 7'd15) bad++;
      end
      chk("bp_hold_stable", bad, 0);
      chk("bp_no_extra_start", start_cyc.size() - sb, 1);
      m_ready = 1'b1;
      h = cyc;
      wait_outs(ob + 3, 400);
      chk("bp_handshake_cycle", out_cyc[ob], h);
      chk("bp_resume_latency", start_cyc[sb + 1] - h, 2);
      chk("bp_out0", out_dat[ob], 15);
      chk("bp_out1", out_dat[ob + 1], 3);
      chk("bp_out2", out_dat[ob + 2], 6);

      // Watchdog
      tick(5);
      sb  = start_cyc.size();
      ob  = out_dat.size();
      tb0 = to_cyc.size();
      enc_hang = 1'b1;
      push(10);
      push(11);
      g = 0;
      while (start_cyc.size() == sb && g < 100) begin
         @(negedge clk);
         g++;
      end
      enc_hang = 1'b0;
      g = 0;
      while (to_cyc.size() == tb0 && g < 300) begin
         @(negedge clk);
         g++;
      end
      chk("wd_fired", int'(to_cyc.size() > tb0), 1);
      chk("wd_delay", to_cyc[tb0] - start_cyc[sb], 64);
      wait_outs(ob + 1, 200);
      tick(3);
      chk("wd_single_pulse", to_cyc.size() - tb0, 1);
      chk("wd_next_word", start_dat[sb + 1], 11);
      chk("wd_next_out", out_dat[ob], 33);
      chk("wd_no_drop_out", out_dat.size() - ob, 1);

      // Out-of-range word
      sb = start_cyc.size();
      ob = out_dat.size();
      eb = err_n;
      push(80);
      push(4);
`ifdef RSA_STREAM_RANGE_CHECK_EN
      wait_outs(ob + 1, 200);
      tick(5);
      chk("rc_err_pulses", err_n - eb, 1);
      chk("rc_start_count", start_cyc.size() - sb, 1);
      chk("rc_start_data", start_dat[sb], 4);
      chk("rc_out", out_dat[ob], 12);
`else
      wait_outs(ob + 2, 400);
      tick(5);
      chk("rc_err_none", err_n - eb, 0);
      chk("rc_fwd_data", start_dat[sb], 80);
      chk("rc_out0", out_dat[ob], 3);
      chk("rc_out1", out_dat[ob + 1], 12);
`endif

      // Reset during WAIT with two words queued
      sb = start_cyc.size();
      push(20);
      push(21);
      push(22);
      g = 0;
      while (start_cyc.size() == sb && g < 100) begin
         @(negedge clk);
         g++;
      end
      tick(5);
      rst = 1'b1;
      #1;
      chk("mid_rst_flags", int'({m_valid, enc_start, busy, timeout, err, s_ready}), 0);
      chk("mid_rst_m_data", int'(m_data), 0);
      chk("mid_rst_enc_data_in", int'(enc_data_in), 0);
      tick(2);
      rst = 1'b0;
      sb = start_cyc.size();
      ob = out_dat.size();
      tick(60);
      chk("post_rst_no_start", start_cyc.size() - sb, 0);
      chk("post_rst_no_out", out_dat.size() - ob, 0);
      chk("post_rst_idle", int'(busy), 0);
      push(7);
      wait_outs(ob + 1, 200);
      chk("post_rst_start_data", start_dat[sb], 7);
      chk("post_rst_out", out_dat[ob], 21);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
